// File: rtl/me_pkg.sv
// Shared definitions for the motion-estimation result serializer: FSM states and default sizes.
package me_pkg;

   localparam int SAD_W_DEF  = 14;
   localparam int MV_W_DEF   = 4;
   localparam int MV_OFS_DEF = 7;
   localparam int DEPTH_DEF  = 2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_PAR   = 2'd2
   } ser_state_e;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/me_result_fifo.sv
// Small count-based result FIFO; read data is the head entry, valid whenever count is non-zero.
module me_result_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 24,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [PTR_W-1:0] wr_ptr_r;
   logic [PTR_W-1:0] rd_ptr_r;
   logic [CNT_W-1:0] count_r;
   logic             full_s;
   logic             empty_s;
   logic             push_ok_s;
   logic             pop_ok_s;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Full/empty derive from the occupancy count; illegal requests are dropped.
   always_comb begin
      full_s    = (count_r == CNT_W'(DEPTH));
      empty_s   = (count_r == '0);
      push_ok_s = push && !full_s && !flush;
      pop_ok_s  = pop && !empty_s && !flush;
   end

   // Entry storage.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push_ok_s) begin
         mem_r[wr_ptr_r] <= wr_data;
      end
   end

   // Pointers and occupancy; flush empties the queue.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_ok_s) begin
            wr_ptr_r <= ptr_inc(wr_ptr_r);
         end
         if (pop_ok_s) begin
            rd_ptr_r <= ptr_inc(rd_ptr_r);
         end
         case ({push_ok_s, pop_ok_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign rd_data = mem_r[rd_ptr_r];
   assign count   = count_r;

endmodule

// File: rtl/me_result_ser.sv
// Serializes queued {SAD, MVx, MVy} results MSB first on three bit lanes.
// Define ME_RESULT_PAR_EN to append an even-parity bit after the SAD LSB.
module me_result_ser
   import me_pkg::*;
#(
   parameter int SAD_W  = SAD_W_DEF,
   parameter int MV_W   = MV_W_DEF,
   parameter int MV_OFS = MV_OFS_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [SAD_W-1:0] sad,
   input  logic [MV_W-1:0]  inx,
   input  logic [MV_W-1:0]  iny,
   output logic             sad_out,
   output logic             x_out,
   output logic             y_out,
   output logic             sad_vld,
   output logic             mv_vld,
   output logic             sad_last,
   output logic             busy
);

   localparam int MV_N = MV_W + 1;
`ifdef ME_RESULT_PAR_EN
   localparam int PAR_LEN = 1;
`else
   localparam int PAR_LEN = 0;
`endif
   localparam int   FRM_LEN     = max_int(SAD_W + PAR_LEN, MV_N);
   localparam int   CNT_W       = $clog2(FRM_LEN + 1);
   localparam int   ENT_W       = SAD_W + 2 * MV_N;
   localparam int   FCNT_W      = $clog2(DEPTH + 1);
   localparam logic LAST_ON_LSB = (PAR_LEN == 0);

   logic [MV_N-1:0]   mv_x_s;
   logic [MV_N-1:0]   mv_y_s;
   logic [ENT_W-1:0]  wr_data_s;
   logic [ENT_W-1:0]  rd_data_s;
   logic [FCNT_W-1:0] fifo_count_s;
   logic [SAD_W-1:0]  ld_sad_s;
   logic [MV_N-1:0]   ld_x_s;
   logic [MV_N-1:0]   ld_y_s;
   logic              in_ready_s;
   logic              push_s;
   logic              pop_s;
   logic              frame_end_s;

   ser_state_e        state_r;
   logic [CNT_W-1:0]  frm_cnt_r;
   logic [SAD_W-1:0]  sad_sr_r;
   logic [MV_N-1:0]   x_sr_r;
   logic [MV_N-1:0]   y_sr_r;
`ifdef ME_RESULT_PAR_EN
   logic              par_r;
`endif
   logic              rdy_en_r;
   logic              sad_out_r;
   logic              x_out_r;
   logic              y_out_r;
   logic              sad_vld_r;
   logic              mv_vld_r;
   logic              sad_last_r;

   function automatic logic sad_parity(input logic [SAD_W-1:0] v);
      return ^v;
   endfunction

   // Centre the raw indices; wrap-around is intentionally unchecked.
   always_comb begin
      mv_x_s    = {1'b0, inx} - MV_N'(MV_OFS);
      mv_y_s    = {1'b0, iny} - MV_N'(MV_OFS);
      wr_data_s = {sad, mv_x_s, mv_y_s};
      ld_sad_s  = rd_data_s[ENT_W-1 -: SAD_W];
      ld_x_s    = rd_data_s[2*MV_N-1 -: MV_N];
      ld_y_s    = rd_data_s[MV_N-1:0];
   end

   // Handshake and pop decisions, all from registered state.
   always_comb begin
      in_ready_s  = rdy_en_r && (fifo_count_s < FCNT_W'(DEPTH)) && !flush;
      push_s      = in_valid && in_ready_s;
      frame_end_s = (state_r != ST_IDLE) && (frm_cnt_r == CNT_W'(FRM_LEN));
      if (flush || (fifo_count_s == '0)) begin
         pop_s = 1'b0;
      end else begin
         pop_s = (state_r == ST_IDLE) || frame_end_s;
      end
   end

   me_result_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (ENT_W),
      .CNT_W (FCNT_W)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .push    (push_s),
      .pop     (pop_s),
      .wr_data (wr_data_s),
      .rd_data (rd_data_s),
      .count   (fifo_count_s)
   );

   // in_ready stays low until the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_r <= 1'b0;
      end else begin
         rdy_en_r <= 1'b1;
      end
   end

   // Serializer FSM; frm_cnt_r counts bits already presented in the current frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r    <= ST_IDLE;
         frm_cnt_r  <= '0;
         sad_sr_r   <= '0;
         x_sr_r     <= '0;
         y_sr_r     <= '0;
`ifdef ME_RESULT_PAR_EN
         par_r      <= 1'b0;
`endif
         sad_out_r  <= 1'b0;
         x_out_r    <= 1'b0;
         y_out_r    <= 1'b0;
         sad_vld_r  <= 1'b0;
         mv_vld_r   <= 1'b0;
         sad_last_r <= 1'b0;
      end else if (flush) begin
         state_r    <= ST_IDLE;
         frm_cnt_r  <= '0;
         sad_sr_r   <= '0;
         x_sr_r     <= '0;
         y_sr_r     <= '0;
`ifdef ME_RESULT_PAR_EN
         par_r      <= 1'b0;
`endif
         sad_out_r  <= 1'b0;
         x_out_r    <= 1'b0;
         y_out_r    <= 1'b0;
         sad_vld_r  <= 1'b0;
         mv_vld_r   <= 1'b0;
         sad_last_r <= 1'b0;
      end else if (pop_s) begin
         // Head entry MSBs go straight onto the lanes; remaining bits queue in the shifters.
         state_r    <= ST_SHIFT;
         frm_cnt_r  <= CNT_W'(1);
         sad_out_r  <= ld_sad_s[SAD_W-1];
         x_out_r    <= ld_x_s[MV_W];
         y_out_r    <= ld_y_s[MV_W];
         sad_sr_r   <= {ld_sad_s[SAD_W-2:0], 1'b0};
         x_sr_r     <= {ld_x_s[MV_W-1:0], 1'b0};
         y_sr_r     <= {ld_y_s[MV_W-1:0], 1'b0};
`ifdef ME_RESULT_PAR_EN
         par_r      <= sad_parity(ld_sad_s);
`endif
         sad_vld_r  <= 1'b1;
         mv_vld_r   <= 1'b1;
         sad_last_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               sad_vld_r  <= 1'b0;
               mv_vld_r   <= 1'b0;
               sad_last_r <= 1'b0;
            end
            ST_SHIFT, ST_PAR: begin
               if (frame_end_s) begin
                  state_r    <= ST_IDLE;
                  frm_cnt_r  <= '0;
                  sad_vld_r  <= 1'b0;
                  mv_vld_r   <= 1'b0;
                  sad_last_r <= 1'b0;
               end else begin
                  frm_cnt_r <= frm_cnt_r + CNT_W'(1);
                  if (frm_cnt_r < CNT_W'(SAD_W)) begin
                     sad_out_r  <= sad_sr_r[SAD_W-1];
                     sad_sr_r   <= {sad_sr_r[SAD_W-2:0], 1'b0};
                     sad_vld_r  <= 1'b1;
                     sad_last_r <= LAST_ON_LSB && (frm_cnt_r == CNT_W'(SAD_W - 1));
`ifdef ME_RESULT_PAR_EN
                  end else if (frm_cnt_r == CNT_W'(SAD_W)) begin
                     state_r    <= ST_PAR;
                     sad_out_r  <= par_r;
                     sad_vld_r  <= 1'b1;
                     sad_last_r <= 1'b1;
`endif
                  end else begin
                     sad_vld_r  <= 1'b0;
                     sad_last_r <= 1'b0;
                  end
                  if (frm_cnt_r < CNT_W'(MV_N)) begin
                     x_out_r  <= x_sr_r[MV_W];
                     y_out_r  <= y_sr_r[MV_W];
                     x_sr_r   <= {x_sr_r[MV_W-1:0], 1'b0};
                     y_sr_r   <= {y_sr_r[MV_W-1:0], 1'b0};
                     mv_vld_r <= 1'b1;
                  end else begin
                     mv_vld_r <= 1'b0;
                  end
               end
            end
            default: begin
               state_r    <= ST_IDLE;
               frm_cnt_r  <= '0;
               sad_vld_r  <= 1'b0;
               mv_vld_r   <= 1'b0;
               sad_last_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready = in_ready_s;
   assign sad_out  = sad_out_r;
   assign x_out    = x_out_r;
   assign y_out    = y_out_r;
   assign sad_vld  = sad_vld_r;
   assign mv_vld   = mv_vld_r;
   assign sad_last = sad_last_r;
   assign busy     = (state_r != ST_IDLE) || (fifo_count_s != '0);

endmodule

// File: tb/tb_me_result_ser.sv
// Directed bench for me_result_ser at default parameters; honours ME_RESULT_PAR_EN.
module tb_me_result_ser;

`ifdef ME_RESULT_PAR_EN
   localparam int FL = 15;
   localparam logic [15:0] SV_EXP = 16'h7FFF;
   localparam logic [15:0] MV_EXP = 16'h7C00;
`else
   localparam int FL = 14;
   localparam logic [15:0] SV_EXP = 16'h3FFF;
   localparam logic [15:0] MV_EXP = 16'h3E00;
`endif

   logic        clk = 1'b0;
   logic        rst_n, flush, in_valid;
   logic [13:0] sad;
   logic [3:0]  inx, iny;
   logic        in_ready, sad_out, x_out, y_out, sad_vld, mv_vld, sad_last, busy;

   always #5 clk = ~clk;

   me_result_ser dut (
      .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .sad(sad), .inx(inx), .iny(iny), .sad_out(sad_out), .x_out(x_out), .y_out(y_out),
      .sad_vld(sad_vld), .mv_vld(mv_vld), .sad_last(sad_last), .busy(busy)
   );

   typedef struct {
      logic [13:0] sad;
      logic [3:0]  inx;
      logic [3:0]  iny;
      logic [13:0] e_sad;
      logic [4:0]  e_x;
      logic [4:0]  e_y;
      logic        e_par;
   } vec_t;

   vec_t vt [5];
   int   tests = 0;
   int   fails = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic drive(input int idx);
      sad = vt[idx].sad;
      inx = vt[idx].inx;
      iny = vt[idx].iny;
   endtask

   task automatic run_frame(input int idx);
      logic [13:0] sw;
      logic [4:0]  xw, yw;
      logic [15:0] sv, mv, lv;
      logic        pb;
      sw = '0; xw = '0; yw = '0; sv = '0; mv = '0; lv = '0; pb = 1'b0;
      @(negedge clk);
      drive(idx);
      in_valid = 1'b1;
      check($sformatf("v%0d_ready", idx), in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("v%0d_latency", idx), {sad_vld, busy}, 2'b01);
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         if (i < 14) sw = {sw[12:0], sad_out};
         else pb = sad_out;
         if (i < 5) begin
            xw = {xw[3:0], x_out};
            yw = {yw[3:0], y_out};
         end
         sv = {sv[14:0], sad_vld};
         mv = {mv[14:0], mv_vld};
         lv = {lv[14:0], sad_last};
      end
      check($sformatf("v%0d_sad", idx), sw, vt[idx].e_sad);
      check($sformatf("v%0d_x", idx), xw, vt[idx].e_x);
      check($sformatf("v%0d_y", idx), yw, vt[idx].e_y);
      check($sformatf("v%0d_sad_vld", idx), sv, SV_EXP);
      check($sformatf("v%0d_mv_vld", idx), mv, MV_EXP);
      check($sformatf("v%0d_last_pos", idx), lv, 16'h0001);
`ifdef ME_RESULT_PAR_EN
      check($sformatf("v%0d_parity", idx), pb, vt[idx].e_par);
`endif
      @(negedge clk);
      check($sformatf("v%0d_end", idx), {sad_vld, mv_vld, sad_last, x_out, y_out, busy},
            {3'b000, vt[idx].e_x[0], vt[idx].e_y[0], 1'b0});
   endtask

   initial begin
      logic [13:0] fw [3];
      int vcnt, lcnt;

      vt[0] = '{14'h2A5B, 4'd0,  4'd14, 14'b10101001011011, 5'b11001, 5'b00111, 1'b0};
      vt[1] = '{14'h0007, 4'd7,  4'd7,  14'b00000000000111, 5'b00000, 5'b00000, 1'b1};
      vt[2] = '{14'h3FFF, 4'd15, 4'd8,  14'b11111111111111, 5'b01000, 5'b00001, 1'b0};
      vt[3] = '{14'h0000, 4'd3,  4'd11, 14'b00000000000000, 5'b11100, 5'b00100, 1'b0};
      vt[4] = '{14'h2000, 4'd15, 4'd0,  14'b10000000000000, 5'b01000, 5'b11001, 1'b1};

      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; sad = '0; inx = '0; iny = '0;
      #12;
      check("reset_outs", {sad_out, x_out, y_out, sad_vld, mv_vld, sad_last, busy}, 7'd0);
      #11 rst_n = 1'b1;
      @(negedge clk);
      check("ready_after_reset", {in_ready, busy}, 2'b10);

      for (int v = 0; v < 5; v++) run_frame(v);

      // Three back-to-back transfers: contiguous frames, in_ready drops when two are queued.
      @(negedge clk);
      drive(0); in_valid = 1'b1;
      @(negedge clk);
      drive(1);
      check("b2b_ready_b", in_ready, 1);
      vcnt = 0; lcnt = 0;
      for (int f = 0; f < 3; f++) fw[f] = '0;
      for (int i = 0; i < 3 * FL; i++) begin
         @(negedge clk);
         if (i == 0) begin
            check("b2b_ready_c", in_ready, 1);
            drive(2);
         end else if (i == 1) begin
            check("b2b_ready_full", in_ready, 0);
            in_valid = 1'b0;
         end
         if ((i % FL) < 14) fw[i / FL] = {fw[i / FL][12:0], sad_out};
         vcnt += int'(sad_vld);
         lcnt += int'(sad_last);
      end
      for (int f = 0; f < 3; f++) check($sformatf("b2b_sad%0d", f), fw[f], vt[f].e_sad);
      check("b2b_vld_cycles", vcnt, 3 * FL);
      check("b2b_last_count", lcnt, 3);
      @(negedge clk);
      check("b2b_idle", {sad_vld, busy}, 2'b00);

      // Flush on bit 5 with one entry queued.
      @(negedge clk);
      drive(0); in_valid = 1'b1;
      @(negedge clk);
      drive(3);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("flush_bit5", {sad_vld, sad_out}, {1'b1, vt[0].e_sad[9]});
      flush = 1'b1;
      #1 check("flush_ready_low", in_ready, 0);
      @(negedge clk);
      flush = 1'b0;
      check("flush_outs", {sad_out, x_out, y_out, sad_vld, mv_vld, sad_last, busy}, 7'd0);
      vcnt = 0;
      for (int i = 0; i < 2 * FL; i++) begin
         @(negedge clk);
         vcnt += int'(sad_vld) + int'(busy);
      end
      check("flush_no_emit", vcnt, 0);

      // Asynchronous reset mid-frame.
      @(negedge clk);
      drive(2); in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (4) @(negedge clk);
      check("rst_midframe_active", {sad_vld, sad_out}, 2'b11);
      #2 rst_n = 1'b0;
      #1 check("rst_async_outs", {sad_out, x_out, y_out, sad_vld, mv_vld, sad_last, busy}, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_release", {in_ready, busy}, 2'b10);
      vcnt = 0;
      for (int i = 0; i < FL; i++) begin
         @(negedge clk);
         vcnt += int'(sad_vld) + int'(mv_vld);
      end
      check("rst_no_resume", vcnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/me_result_ser.md
ME_RESULT_SER -- requirements
Module: me_result_ser

Interface
REQ-001 SHALL have parameter SAD_W, default 14, SAD word width (4..16).
REQ-002 SHALL have parameter MV_W, default 4, raw motion-vector index width; serialized MV is MV_W+1 bits signed.
REQ-003 SHALL have parameter MV_OFS, default 7, search-window centre subtracted from raw indices.
REQ-004 SHALL have parameter DEPTH, default 2, result FIFO depth (power of two, 1..8).
REQ-005 SHALL have: clk  in  1  sole clock, rising edge.
REQ-006 SHALL have: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have: flush  in  1  synchronous abort; clears FIFO and serializer.
REQ-008 SHALL have: in_valid  in  1  result word offered.
REQ-009 SHALL have: in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready.
REQ-010 SHALL have: sad  in  SAD_W  unsigned best SAD.
REQ-011 SHALL have: inx, iny  in  MV_W  unsigned raw MV indices.
REQ-012 SHALL have: sad_out, x_out, y_out  out  1  serial data, MSB first.
REQ-013 SHALL have: sad_vld, mv_vld  out  1  qualifiers for sad_out and x_out/y_out.
REQ-014 SHALL have: sad_last  out  1  high on final sad_out bit of a frame.
REQ-015 SHALL have: busy  out  1  serializer active or FIFO non-empty.

Function
REQ-016 SHALL store {sad, inx-MV_OFS, iny-MV_OFS} in the FIFO on each transfer; MV subtraction in MV_W+1-bit two's complement, wrap-around not checked.
REQ-017 SHALL drive in_ready = (FIFO count < DEPTH) && !flush, from registered count.
REQ-018 SHALL implement FSM IDLE, SHIFT (plus PAR under ME_RESULT_PAR_EN); IDLE->SHIFT on an edge where count>0, popping one entry.
REQ-019 SHALL, on the SHIFT entry edge, drive sad_out=SAD[SAD_W-1], x_out/y_out=MV[MV_W], sad_vld=mv_vld=1; latency transfer-edge to first bit = 1 cycle when idle and empty (no combinational bypass).
REQ-020 SHALL shift SAD for exactly SAD_W cycles and MV for exactly MV_W+1 cycles, both starting together; mv_vld drops after MV LSB, x_out/y_out hold last bit.
REQ-021 SHALL assert sad_last with SAD LSB (or parity bit when enabled); if MV_W+1 > SAD_W, frame ends with MV LSB and sad_last with SAD LSB.
REQ-022 SHALL, at frame end with count>0, pop next entry and output its MSB on the following edge (back-to-back, zero gap); else return to IDLE with sad_vld=mv_vld=0, data outputs holding.
REQ-023 SHALL allow push and pop on the same edge; count unchanged; push when full impossible (in_ready low).
REQ-024 SHALL, on flush, next edge: FIFO empty, FSM IDLE, all outputs 0; flush overrides simultaneous in_valid and pop.

Reset
REQ-025 SHALL on rst_n low, asynchronously: FSM IDLE, FIFO empty, bit counters 0, sad_out=x_out=y_out=sad_vld=mv_vld=sad_last=busy=0, in_ready=1 from first edge after release.
REQ-026 SHALL abandon any frame in progress on reset mid-frame; no partial frame resumes.

Configuration
REQ-027 SHALL with ME_RESULT_PAR_EN defined append one PAR cycle after SAD LSB: sad_out = even parity of SAD (XOR of bits), sad_vld=1, sad_last=1; frame SAD_W+1 cycles.
REQ-028 SHALL without ME_RESULT_PAR_EN omit PAR state; frame max(SAD_W, MV_W+1) cycles.

Structure
REQ-029 SHALL place state enum, default widths and MV_OFS default in shared package me_pkg.
REQ-030 SHALL instantiate one sub-module me_result_fifo (DEPTH, width SAD_W+2*(MV_W+1)), count-based full/empty.

Verification
REQ-031 Single result sad=14'h2A5B, inx=0, iny=14 -> sad_out 10101001011011 over 14 cycles, x_out 11001 (-7), y_out 00111 (+7), sad_last on cycle 14.
REQ-032 Three back-to-back transfers, DEPTH=2 -> in_ready low after 2nd stored while first serializes, frames contiguous with no idle cycle.
REQ-033 flush asserted on bit 5 of frame with one entry queued -> outputs 0 next edge, busy=0, queued entry never emitted.
REQ-034 rst_n pulsed low mid-frame (async, between edges) -> outputs 0 immediately, in_ready=1 after release.
REQ-035 ME_RESULT_PAR_EN, sad=14'h0007 -> 15th sad_out bit 1 with sad_last; without macro sad_last on 14th bit.
